// File: rtl/seq_state_reg.sv
// State register for an externally computed sequence detector: holds the current
// state, emits a detect pulse on entry to s3, and counts accepted bits and s3 entries.
module seq_state_reg #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             clr,
   input  logic [1:0]       nextstate,
   output logic             tf_in,
   output logic [1:0]       currstate,
   output logic             detect,
   output logic [CNT_W-1:0] det_count,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] DET_MAX = '1;

   state_t           r_state;
   logic             r_detect;
   logic [CNT_W-1:0] r_det_count;
   logic [CNT_W-1:0] r_bit_count;

   state_t           w_state_next;
   logic             w_detect_next;
   logic [CNT_W-1:0] w_det_count_next;
   logic [CNT_W-1:0] w_bit_count_next;
   logic             w_hit;

   // nextstate is only sampled on an accepted bit, so it may glitch freely otherwise
   assign w_hit = (state_t'(nextstate) == S3);

   always_comb begin
      w_state_next     = r_state;
      w_detect_next    = 1'b0;
      w_det_count_next = r_det_count;
      w_bit_count_next = r_bit_count;
      if (clr) begin
         w_state_next     = S0;
         w_det_count_next = '0;
         w_bit_count_next = '0;
      end else if (in_valid) begin
         w_state_next     = state_t'(nextstate);
         w_detect_next    = w_hit;
         w_bit_count_next = r_bit_count + 1'b1;
         if (w_hit && (r_det_count != DET_MAX)) begin
            w_det_count_next = r_det_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S0;
         r_detect    <= 1'b0;
         r_det_count <= '0;
         r_bit_count <= '0;
      end else begin
         r_state     <= w_state_next;
         r_detect    <= w_detect_next;
         r_det_count <= w_det_count_next;
         r_bit_count <= w_bit_count_next;
      end
   end

   assign tf_in     = in_bit;
   assign currstate = r_state;
   assign detect    = r_detect;
   assign det_count = r_det_count;
   assign bit_count = r_bit_count;

endmodule

// File: tb/tb_seq_state_reg.sv
// Directed bench for seq_state_reg; closes the loop through a model of the
// transition function and checks outputs 1 time unit after each rising edge.
module tb_seq_state_reg;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             in_bit;
   logic             in_valid;
   logic             clr;
   logic [1:0]       nextstate;
   logic             tf_in;
   logic [1:0]       currstate;
   logic             detect;
   logic [CNT_W-1:0] det_count;
   logic [CNT_W-1:0] bit_count;
   logic             glitch;

   int checks = 0;
   int errors = 0;

   seq_state_reg #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .clr       (clr),
      .nextstate (nextstate),
      .tf_in     (tf_in),
      .currstate (currstate),
      .detect    (detect),
      .det_count (det_count),
      .bit_count (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] tf(input logic [1:0] s, input logic b);
      logic [1:0] r;
      case ({b, s})
         3'b000: r = 2'b01;
         3'b001: r = 2'b00;
         3'b010: r = 2'b01;
         3'b011: r = 2'b01;
         3'b100: r = 2'b10;
         3'b101: r = 2'b10;
         3'b110: r = 2'b11;
         default: r = 2'b10;
      endcase
      return r;
   endfunction

   // glitch forces a bogus s3 onto nextstate to prove it is ignored while idle
   assign nextstate = glitch ? 2'b11 : tf(currstate, tf_in);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic b);
      in_bit   = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("bit %0b -> state %02b detect %0b det_count %0d bit_count %0d",
               b, currstate, detect, det_count, bit_count);
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic dt,
                            input int dc, input int bc);
      check({tag, ".state"},  32'(currstate), 32'(st));
      check({tag, ".detect"}, 32'(detect),    32'(dt));
      check({tag, ".det"},    32'(det_count), 32'(dc));
      check({tag, ".bits"},   32'(bit_count), 32'(bc));
   endtask

   initial begin
      logic [1:0] exp_st [4];
      logic       exp_dt [4];
      logic       stream [4];
      stream = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_st = '{2'b10, 2'b11, 2'b10, 2'b01};
      exp_dt = '{1'b0, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b1; in_bit = 1'b0; in_valid = 1'b0; clr = 1'b0; glitch = 1'b0;

      // Reset asserted between edges takes effect immediately
      #2 rst_n = 1'b0;
      #1 check_all("reset", 2'b00, 1'b0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         send(stream[i]);
         check($sformatf("stream%0d.state", i),  32'(currstate), 32'(exp_st[i]));
         check($sformatf("stream%0d.detect", i), 32'(detect),    32'(exp_dt[i]));
      end
      check("stream.det",  32'(det_count), 32'd1);
      check("stream.bits", 32'(bit_count), 32'd4);

      // Stall in s2 with toggling data and a glitching nextstate
      send(1'b1);
      check_all("to_s2", 2'b10, 1'b0, 1, 5);
      for (int i = 0; i < 3; i++) begin
         in_bit = i[0];
         glitch = 1'b1;
         @(posedge clk);
         #1;
         check_all($sformatf("stall%0d", i), 2'b10, 1'b0, 1, 5);
         check($sformatf("stall%0d.tf_in", i), 32'(tf_in), 32'(in_bit));
      end
      glitch = 1'b0;
      send(1'b1);
      check_all("unstall", 2'b11, 1'b1, 2, 6);
      @(posedge clk);
      #1;
      check_all("idle_after_hit", 2'b11, 1'b0, 2, 6);

      // Clear beats a valid bit in s2
      send(1'b1);
      check_all("pre_clr", 2'b10, 1'b0, 2, 7);
      clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0; in_valid = 1'b0;
      check_all("clr", 2'b00, 1'b0, 0, 0);

      // Saturation: each 1,1,0,0 group is one s3 entry ending back in s0
      for (int g = 1; g <= 22; g++) begin
         send(1'b1);
         send(1'b1);
         if (g == 22) check("sat.detect_at_max", 32'(detect), 32'd1);
         send(1'b0);
         send(1'b0);
         if (g == 10) check_all("sat10", 2'b00, 1'b0, 10, 8);
         if (g == 15) check("sat15.det", 32'(det_count), 32'd15);
      end
      check_all("sat22", 2'b00, 1'b0, 15, 8);

      // Mid-stream reset from s3 with det_count=5
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int g = 0; g < 4; g++) begin
         send(1'b1); send(1'b1); send(1'b0); send(1'b0);
      end
      send(1'b1);
      send(1'b1);
      check_all("pre_rst", 2'b11, 1'b1, 5, 2);
      rst_n = 1'b0;
      #1 check_all("mid_rst", 2'b00, 1'b0, 0, 0);
      #1 rst_n = 1'b1;
      send(1'b1);
      check_all("post_rst1", 2'b10, 1'b0, 0, 1);
      send(1'b1);
      check_all("post_rst2", 2'b11, 1'b1, 1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_state_reg.md
SEQ_STATE_REG -- requirements
Module: seq_state_reg

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of both counters; legal range is 2 to 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_bit  input  1  SHALL carry the serial data bit.
REQ-005 in_valid  input  1  SHALL qualify in_bit; a bit is accepted on a rising clk edge where in_valid=1.
REQ-006 clr  input  1  SHALL be a synchronous clear of the state and both counters.
REQ-007 nextstate  input  2  SHALL carry the next state from the combinational state transition function block.
REQ-008 tf_in  output  1  SHALL drive the transition function input; it equals in_bit combinationally.
REQ-009 currstate  output  2  SHALL be the registered current state; it feeds the transition function.
REQ-010 detect  output  1  SHALL be a registered one-cycle pulse: the accepted bit moved the FSM into s3.
REQ-011 det_count  output  CNT_W  SHALL count s3 entries and saturate at its maximum value.
REQ-012 bit_count  output  CNT_W  SHALL count accepted bits and wrap modulo 2^CNT_W.

Function
REQ-013 State encoding SHALL be s0=00, s1=01, s2=10, s3=11; all four codes are legal.
REQ-014 The transition function SHALL map in=0 to next states s1,s0,s1,s1 and in=1 to s2,s2,s3,s2, for s0,s1,s2,s3 respectively; benches model this table.
REQ-015 On an accepted bit with clr=0, currstate SHALL load nextstate on that edge (one-cycle latency).
REQ-016 On an accepted bit with clr=0, detect SHALL load (nextstate==11); otherwise detect SHALL load 0.
REQ-017 Hence detect SHALL be high for exactly the one cycle after the accepting edge, and never for two consecutive cycles unless bits are accepted back-to-back and each reaches s3.
REQ-018 On an accepted bit with nextstate==11 and det_count below its maximum, det_count SHALL increment by 1; at 2^CNT_W-1 it SHALL hold.
REQ-019 On an accepted bit, bit_count SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-020 With in_valid=0 and clr=0, currstate, det_count and bit_count SHALL hold and detect SHALL be 0.
REQ-021 clr=1 SHALL take priority over in_valid: currstate<=00, detect<=0, det_count<=0, bit_count<=0; the bit presented in that cycle is discarded.
REQ-022 The block SHALL NOT register nextstate outside an accepted edge, so glitches on nextstate while in_valid=0 have no effect.

Reset
REQ-023 rst_n=0 SHALL force currstate=00, detect=0, det_count=0 and bit_count=0 immediately, independent of clk.
REQ-024 Reset SHALL override clr and in_valid; it has effect mid-stream, and any partially detected pattern is lost.
REQ-025 The first bit SHALL be accepted on the first rising clk edge after rst_n deasserts where in_valid=1.

Verification
REQ-026 Reset check: assert rst_n=0 between edges -> all outputs go to 0 at once, with no clk edge.
REQ-027 Bit stream 1,1,1,0 with in_valid=1 from s0 -> currstate sequence 10,11,10,01; detect sequence 0,1,0,0; det_count=1; bit_count=4.
REQ-028 Stall check: from s2, drive in_valid=0 for 3 cycles while toggling in_bit -> currstate stays 10, detect=0, counters unchanged; then accept 1 -> currstate=11 and detect=1.
REQ-029 Saturation check: CNT_W=4, drive 40 accepted bits of alternating pairs 1,1,0,0 (10 s3 entries), then 12 more entries -> det_count=15 holds; bit_count wraps correctly modulo 16.
REQ-030 Clear priority check: clr=1 with in_valid=1, in_bit=1 in state s2 -> next cycle currstate=00, detect=0, both counters 0.
REQ-031 Mid-stream reset check: pulse rst_n low in state s3 with det_count=5 -> outputs are 0 immediately; the following bits 1,1 -> detect pulses on the second bit and det_count=1.
